// File: rtl/mips32_mem_arbiter.sv
// Shared single-port memory arbiter: the load/store port has priority over
// instruction fetch, with a starvation guard so fetch always progresses.
module mips32_mem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [3:0]        starve_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int unsigned CNT_W = 4;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             owner_dm;
  logic             any_req;
  logic             if_wins;

  // IF beats a concurrent DM request only once it has lost STARVE_LIMIT rounds
  assign any_req = if_req | dm_req;
  assign if_wins = if_req & (~dm_req |
                   ((STARVE_LIMIT != 0) && (starve_cnt == CNT_W'(STARVE_LIMIT))));

  always_ff @(posedge clk1) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_ISSUE;
          if (if_wins) if_gnt = 1'b1;
          else         dm_gnt = 1'b1;
        end
      end
      S_ISSUE: state_nxt = mem_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (lat_cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: memory strobes, latency countdown, response capture, starvation count
  always_ff @(posedge clk1) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      owner_dm   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      busy      <= (state_nxt != S_IDLE);

      if (if_gnt) begin
        mem_en   <= 1'b1;
        mem_addr <= if_addr;
        owner_dm <= 1'b0;
      end else if (dm_gnt) begin
        mem_en    <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        owner_dm  <= 1'b1;
      end

      if (state == S_IDLE && any_req) begin
        if (if_req && dm_gnt) begin
          if (starve_cnt != 4'd15) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= '0;
        end
      end

      if (state == S_ISSUE) lat_cnt <= CNT_W'(MEM_LATENCY);

      if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
        if (lat_cnt == CNT_W'(1)) begin
          if (owner_dm) begin
            dm_rdata  <= mem_rdata;
            dm_rvalid <= 1'b1;
          end else begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
